// File: rtl/sha1_wb_pkg.sv
// Register map, OPS bit positions, status words and enums shared by the SHA1 Wishbone host.
// Pure declarations; adds no logic or latency of its own.
package sha1_wb_pkg;

  localparam logic [31:0] REG_NR     = 32'h0;
  localparam logic [31:0] REG_ID     = 32'h4;
  localparam logic [31:0] REG_OPS    = 32'h8;
  localparam logic [31:0] REG_MSG_IN = 32'hC;
  localparam logic [31:0] REG_DIGEST = 32'h10;
  localparam logic [31:0] REG_PANIC  = 32'h14;

  localparam int OPS_ON    = 0;
  localparam int OPS_RESET = 1;
  localparam int OPS_PANIC = 2;
  localparam int OPS_DONE  = 3;

  localparam logic [31:0] CTRL_ID = 32'h53484131;
  localparam logic [31:0] ACK     = 32'h1;
  localparam logic [31:0] EINVAL  = 32'hffffffea;
  localparam logic [31:0] EBUSY   = 32'hfffffff0;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_ACK_TMO    = 3'd1,
    ERR_MSG_NACK   = 3'd2,
    ERR_POLL_LIMIT = 3'd3,
    ERR_PANIC      = 3'd4,
    ERR_EBUSY      = 3'd5,
    ERR_ID         = 3'd6
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_RD,
    ST_RST_WR,
    ST_MSG_WR,
    ST_POLL_RD,
    ST_DIG_RD,
    ST_OFF_WR
  } state_t;

endpackage

// File: rtl/sha1_wb_xfer.sv
// Single Wishbone transfer engine: launches on req while idle, holds cyc/stb until ack or ACK_TIMEOUT cycles.
// done/timeout are flagged combinationally in the final bus cycle; the bus drops on the following cycle.
module sha1_wb_xfer #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  logic       active;
  logic [7:0] timer;
  logic       last_cycle;

  assign last_cycle = (timer == ACK_TIMEOUT - 8'd1);
  assign busy       = active;
  assign done       = active & wbm_ack_i;
  assign timeout    = active & ~wbm_ack_i & last_cycle;
  assign rdata      = wbm_dat_i;
  assign wbm_cyc_o  = active;
  assign wbm_stb_o  = active;
  assign wbm_sel_o  = {4{active}};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      active    <= 1'b0;
      timer     <= 8'd0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
    end else if (active) begin
      if (wbm_ack_i || last_cycle) active <= 1'b0;
      timer <= timer + 8'd1;
    end else if (req) begin
      active    <= 1'b1;
      timer     <= 8'd0;
      wbm_we_o  <= we;
      wbm_adr_o <= adr;
      wbm_dat_o <= wdata;
    end
  end

endmodule

// File: rtl/sha1_wb_host.sv
// Drives the SHA1 peripheral through one block: clear, 16 MSG_IN writes, poll DONE, 5 digest reads, engine off.
// Two cycles per zero-wait transfer; msg_valid_i low stalls with the bus idle. SHA1_WB_HOST_ID_CHECK_EN adds an ID read.
module sha1_wb_host
  import sha1_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter logic [7:0]  ACK_TIMEOUT  = 8'd255,
  parameter logic [15:0] POLL_LIMIT   = 16'd2000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  input  logic        start_i,
  input  logic        msg_valid_i,
  input  logic [31:0] msg_data_i,
  output logic        msg_ready_o,
  output logic        dig_valid_o,
  output logic [31:0] dig_data_o,
  output logic [2:0]  dig_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  state_t      state, state_nxt;
  err_code_t   err_code, err_new;
  logic        err_set;
  logic [3:0]  cnt;
  logic [15:0] poll_cnt;
  logic        x_req, x_we, x_busy, x_done, x_tmo;
  logic [31:0] x_adr, x_wdata, x_rdata;

  sha1_wb_xfer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .req(x_req), .we(x_we), .adr(x_adr), .wdata(x_wdata),
    .busy(x_busy), .done(x_done), .timeout(x_tmo), .rdata(x_rdata),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_new   = ERR_NONE;
    if (x_tmo) begin
      // A failing engine-off write must not mask the error that led there.
      if (state == ST_OFF_WR) begin
        state_nxt = ST_IDLE;
      end else begin
        err_set   = 1'b1;
        err_new   = ERR_ACK_TMO;
        state_nxt = ST_OFF_WR;
      end
    end else if (x_done) begin
      case (state)
`ifdef SHA1_WB_HOST_ID_CHECK_EN
        ST_ID_RD: begin
          if (x_rdata != CTRL_ID) begin
            err_set = 1'b1; err_new = ERR_ID; state_nxt = ST_OFF_WR;
          end else state_nxt = ST_RST_WR;
        end
`endif
        ST_RST_WR: state_nxt = ST_MSG_WR;
        ST_MSG_WR: begin
          if (x_rdata != ACK) begin
            err_set = 1'b1; err_new = ERR_MSG_NACK; state_nxt = ST_OFF_WR;
          end else if (cnt == 4'd15) state_nxt = ST_POLL_RD;
        end
        ST_POLL_RD: begin
          if (x_rdata[OPS_PANIC]) begin
            err_set = 1'b1; err_new = ERR_PANIC; state_nxt = ST_OFF_WR;
          end else if (x_rdata[OPS_DONE]) begin
            state_nxt = ST_DIG_RD;
          end else if (poll_cnt >= POLL_LIMIT) begin
            err_set = 1'b1; err_new = ERR_POLL_LIMIT; state_nxt = ST_OFF_WR;
          end
        end
        ST_DIG_RD: begin
          if (x_rdata == EBUSY) begin
            err_set = 1'b1; err_new = ERR_EBUSY; state_nxt = ST_OFF_WR;
          end else if (cnt == 4'd4) state_nxt = ST_OFF_WR;
        end
        ST_OFF_WR: state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (state == ST_IDLE && start_i) begin
`ifdef SHA1_WB_HOST_ID_CHECK_EN
      state_nxt = ST_ID_RD;
`else
      state_nxt = ST_RST_WR;
`endif
    end
  end

  always_comb begin
    x_req       = 1'b0;
    x_we        = 1'b0;
    x_adr       = BASE_ADDRESS;
    x_wdata     = 32'h0;
    msg_ready_o = 1'b0;
    case (state)
      ST_ID_RD:   begin x_req = ~x_busy; x_adr = BASE_ADDRESS + REG_ID; end
      ST_RST_WR:  begin
        x_req = ~x_busy; x_we = 1'b1; x_adr = BASE_ADDRESS + REG_OPS; x_wdata = 32'h1 << OPS_RESET;
      end
      ST_MSG_WR:  begin
        x_req = ~x_busy & msg_valid_i; x_we = 1'b1; x_adr = BASE_ADDRESS + REG_MSG_IN;
        x_wdata = msg_data_i; msg_ready_o = ~x_busy & msg_valid_i;
      end
      ST_POLL_RD: begin x_req = ~x_busy; x_adr = BASE_ADDRESS + REG_OPS; end
      ST_DIG_RD:  begin x_req = ~x_busy; x_adr = BASE_ADDRESS + REG_DIGEST; end
      ST_OFF_WR:  begin x_req = ~x_busy; x_we = 1'b1; x_adr = BASE_ADDRESS + REG_OPS; end
      default:    ;
    endcase
  end

  assign busy_o     = (state != ST_IDLE);
  assign err_code_o = err_code;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt         <= 4'd0;
      poll_cnt    <= 16'd0;
      err_code    <= ERR_NONE;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      dig_valid_o <= 1'b0;
      dig_data_o  <= 32'h0;
      dig_idx_o   <= 3'd0;
    end else begin
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      dig_valid_o <= 1'b0;
      if (state == ST_IDLE && start_i) begin
        err_code <= ERR_NONE;
        cnt      <= 4'd0;
        poll_cnt <= 16'd0;
      end
      if (err_set && err_code == ERR_NONE) err_code <= err_new;
      if (x_done && !err_set) begin
        // cnt wraps 15->0 after the last message word, so the digest reads start from index 0.
        if (state == ST_MSG_WR) cnt <= cnt + 4'd1;
        if (state == ST_POLL_RD) poll_cnt <= poll_cnt + 16'd1;
        if (state == ST_DIG_RD) begin
          dig_valid_o <= 1'b1;
          dig_data_o  <= x_rdata;
          dig_idx_o   <= cnt[2:0];
          cnt         <= cnt + 4'd1;
        end
      end
      if (state == ST_OFF_WR && (x_done || x_tmo)) begin
        if (err_code == ERR_NONE) done_o <= 1'b1;
        else                      err_o  <= 1'b1;
      end
    end
  end

endmodule
